// File: rtl/ifetch_unit.sv
// ifetch_unit: instruction fetch stage feeding the instruction decoder.
// Holds the PC, fetches one instruction word at a time from instruction memory
// over a req/ack handshake, latches it into the instruction register, and
// computes the next PC from the decoder's branch controls once the instruction
// leaves EXEC.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   stall             hold the instruction currently in EXEC
//   bs, ps            branch select / branch polarity from the decoder
//   zero_flag         ALU zero flag for the instruction in EXEC
//   jump_addr         absolute jump target (register A value)
//   imem_rdata/ack    instruction memory read data and valid
//   imem_req/addr     instruction memory read request (registered) and address
//   instruction_out   instruction register, drives the decoder
//   ir_valid          instruction_out is valid for execution
//   pc_out            address of the instruction held in instruction_out
module ifetch_unit #(
  parameter int unsigned          INS_WIDTH    = 17,
  parameter int unsigned          PC_WIDTH     = 8,
  parameter logic [PC_WIDTH-1:0]  RESET_VECTOR = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 stall,
  input  logic [1:0]           bs,
  input  logic                 ps,
  input  logic                 zero_flag,
  input  logic [PC_WIDTH-1:0]  jump_addr,
  input  logic [INS_WIDTH-1:0] imem_rdata,
  input  logic                 imem_ack,
  output logic                 imem_req,
  output logic [PC_WIDTH-1:0]  imem_addr,
  output logic [INS_WIDTH-1:0] instruction_out,
  output logic                 ir_valid,
  output logic [PC_WIDTH-1:0]  pc_out
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2
  } state_t;

  state_t               state_q,    state_d;
  logic [PC_WIDTH-1:0]  pc_q,       pc_d;
  logic                 req_q,      req_d;
  logic [INS_WIDTH-1:0] ir_q,       ir_d;
  logic                 ir_valid_q, ir_valid_d;
  logic [PC_WIDTH-1:0]  pc_out_q,   pc_out_d;

  logic [5:0]           off;
  logic [PC_WIDTH-1:0]  off_ext;
  logic [PC_WIDTH-1:0]  pc_inc;
  logic [PC_WIDTH-1:0]  pc_rel;
  logic                 taken;
  logic [PC_WIDTH-1:0]  next_pc;

  // Branch offset is split across the DA and BA fields of the instruction.
  // Relative targets are measured from the branch's own address.
  always_comb begin
    off     = {ir_q[11:9], ir_q[5:3]};
    off_ext = {{(PC_WIDTH-6){off[5]}}, off};
    pc_inc  = pc_q + PC_WIDTH'(1);
    pc_rel  = pc_q + off_ext;
    taken   = ~(zero_flag ^ ps);
    case (bs)
      2'b00:   next_pc = pc_inc;
      2'b01:   next_pc = taken ? pc_rel : pc_inc;
      2'b10:   next_pc = jump_addr;
      default: next_pc = pc_rel;
    endcase
  end

  // imem_req and ir_valid are registered, so they are set according to the
  // state being entered rather than the current one.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_d      = req_q;
    ir_d       = ir_q;
    ir_valid_d = ir_valid_q;
    pc_out_d   = pc_out_q;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_FETCH;
        req_d   = 1'b1;
      end
      ST_FETCH: begin
        if (imem_ack) begin
          ir_d       = imem_rdata;
          pc_out_d   = pc_q;
          ir_valid_d = 1'b1;
          req_d      = 1'b0;
          state_d    = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (!stall) begin
          pc_d       = next_pc;
          ir_valid_d = 1'b0;
          req_d      = 1'b1;
          state_d    = ST_FETCH;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        req_d      = 1'b0;
        ir_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_VECTOR;
      req_q      <= 1'b0;
      ir_q       <= '0;
      ir_valid_q <= 1'b0;
      pc_out_q   <= RESET_VECTOR;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_q      <= req_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
      pc_out_q   <= pc_out_d;
    end
  end

  assign imem_req        = req_q;
  assign imem_addr       = pc_q;
  assign instruction_out = ir_q;
  assign ir_valid        = ir_valid_q;
  assign pc_out          = pc_out_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Testbench for ifetch_unit: startup cadence, ack wait states, stall hold,
// branch/jump/wrap vectors, randomized fetch/execute traffic against a
// transaction-level PC model, and reset during a pending fetch.
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic [1:0]  bs;
  logic        ps;
  logic        zero_flag;
  logic [7:0]  jump_addr;
  logic [16:0] imem_rdata;
  logic        imem_ack;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic [16:0] instruction_out;
  logic        ir_valid;
  logic [7:0]  pc_out;

  logic [16:0] mem [256];
  logic        ack_auto;
  logic        ack_man;
  logic [16:0] rd_xor;

  int checks = 0;
  int errors = 0;
  int model_pc;

  always #5 clk = ~clk;

  assign imem_rdata = mem[imem_addr] ^ rd_xor;
  assign imem_ack   = ack_auto ? imem_req : ack_man;

  ifetch_unit #(
    .INS_WIDTH(17),
    .PC_WIDTH(8),
    .RESET_VECTOR(8'h00)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .stall(stall),
    .bs(bs),
    .ps(ps),
    .zero_flag(zero_flag),
    .jump_addr(jump_addr),
    .imem_rdata(imem_rdata),
    .imem_ack(imem_ack),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .instruction_out(instruction_out),
    .ir_valid(ir_valid),
    .pc_out(pc_out)
  );

  typedef struct {
    logic [7:0]  pc;
    logic [16:0] ins;
    logic [1:0]  bs;
    logic        ps;
    logic        z;
    logic [7:0]  jmp;
    logic [7:0]  exp;
  } vec_t;

  vec_t vecs [9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Next-PC reference computed from the branch rules with plain integers.
  function automatic int ref_next(input int pc, input logic [16:0] ins, input logic [1:0] b,
                                  input logic p, input logic zf, input int jmp);
    logic [5:0] o6;
    int off;
    o6  = {ins[11:9], ins[5:3]};
    off = int'(o6);
    if (off >= 32) off -= 64;
    case (b)
      2'd0:    return (pc + 1) % 256;
      2'd1:    return (zf == p) ? (pc + off + 256) % 256 : (pc + 1) % 256;
      2'd2:    return jmp % 256;
      default: return (pc + off + 256) % 256;
    endcase
  endfunction

  // Complete one fetch of address exp_pc with 'delay' wait cycles before ack.
  task automatic do_fetch(input int exp_pc, input int delay);
    int n = 0;
    ack_man = 1'b0;
    rd_xor  = '0;
    while (!imem_req && n < 10) begin
      tick();
      n++;
    end
    check("req_seen", 32'(imem_req), 32'd1);
    for (int d = 0; d < delay; d++) begin
      check("wait_req", 32'(imem_req), 32'd1);
      check("wait_addr", 32'(imem_addr), 32'(exp_pc));
      check("wait_valid", 32'(ir_valid), 32'd0);
      tick();
    end
    check("fetch_addr", 32'(imem_addr), 32'(exp_pc));
    ack_man = 1'b1;
    tick();
    ack_man = 1'b0;
    check("ack_valid", 32'(ir_valid), 32'd1);
    check("ack_req", 32'(imem_req), 32'd0);
    check("ack_instr", 32'(instruction_out), 32'(mem[exp_pc]));
    check("ack_pc_out", 32'(pc_out), 32'(exp_pc));
  endtask

  // Hold EXEC for nstall cycles (with stray acks and altered read data), then
  // release with the given branch controls and check the next fetch address.
  task automatic do_exec(input int nstall, input logic [1:0] b, input logic p,
                         input logic zf, input logic [7:0] j);
    logic [16:0] ins;
    int nxt;
    ins = mem[model_pc];
    for (int s = 0; s < nstall; s++) begin
      stall     = 1'b1;
      bs        = 2'($urandom);
      ps        = 1'($urandom);
      zero_flag = 1'($urandom);
      jump_addr = 8'($urandom);
      ack_man   = 1'($urandom);
      rd_xor    = 17'($urandom) | 17'd1;
      tick();
      check("stall_valid", 32'(ir_valid), 32'd1);
      check("stall_req", 32'(imem_req), 32'd0);
      check("stall_instr", 32'(instruction_out), 32'(ins));
      check("stall_pc_out", 32'(pc_out), 32'(model_pc));
    end
    stall     = 1'b0;
    bs        = b;
    ps        = p;
    zero_flag = zf;
    jump_addr = j;
    ack_man   = 1'($urandom);
    rd_xor    = 17'($urandom) | 17'd1;
    tick();
    ack_man = 1'b0;
    rd_xor  = '0;
    nxt = ref_next(model_pc, ins, b, p, zf, int'(j));
    check("exec_valid", 32'(ir_valid), 32'd0);
    check("exec_req", 32'(imem_req), 32'd1);
    check("next_addr", 32'(imem_addr), 32'(nxt));
    model_pc = nxt;
  endtask

  initial begin
    vecs[0] = '{8'h05, 17'b00010_111_000_110_000, 2'b01, 1'b1, 1'b1, 8'h00, 8'h03};
    vecs[1] = '{8'h05, 17'b00010_111_000_110_000, 2'b01, 1'b1, 1'b0, 8'h00, 8'h06};
    vecs[2] = '{8'h05, 17'b00010_111_000_110_000, 2'b11, 1'b0, 1'b0, 8'h00, 8'h03};
    vecs[3] = '{8'h05, 17'b00010_111_000_110_000, 2'b01, 1'b0, 1'b1, 8'h00, 8'h06};
    vecs[4] = '{8'h05, 17'b00010_111_000_110_000, 2'b01, 1'b0, 1'b0, 8'h00, 8'h03};
    vecs[5] = '{8'h09, 17'h0_0000,                2'b10, 1'b0, 1'b0, 8'h40, 8'h40};
    vecs[6] = '{8'hFF, 17'h1_2345,                2'b00, 1'b1, 1'b1, 8'h00, 8'h00};
    vecs[7] = '{8'h02, 17'b00000_111_000_100_000, 2'b11, 1'b0, 1'b0, 8'h00, 8'hFE};
    vecs[8] = '{8'hF0, 17'b00000_011_000_111_000, 2'b11, 1'b0, 1'b0, 8'h00, 8'h0F};

    for (int i = 0; i < 256; i++) mem[i] = 17'($urandom);

    rst_n = 1'b0; stall = 1'b0; bs = 2'b00; ps = 1'b0; zero_flag = 1'b0;
    jump_addr = 8'h00; ack_auto = 1'b0; ack_man = 1'b0; rd_xor = '0;
    tick();
    tick();
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_valid", 32'(ir_valid), 32'd0);
    check("rst_instr", 32'(instruction_out), 32'd0);
    check("rst_pc_out", 32'(pc_out), 32'd0);
    check("rst_addr", 32'(imem_addr), 32'd0);

    // Startup with ack tied to req: 2-cycle cadence through addresses 0..3.
    ack_auto = 1'b1;
    rst_n    = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (k % 2 == 0) begin
        check("boot_req", 32'(imem_req), 32'd1);
        check("boot_addr", 32'(imem_addr), 32'(k / 2));
        check("boot_valid", 32'(ir_valid), 32'd0);
      end else begin
        check("boot_valid", 32'(ir_valid), 32'd1);
        check("boot_req", 32'(imem_req), 32'd0);
        check("boot_instr", 32'(instruction_out), 32'(mem[k / 2]));
        check("boot_pc_out", 32'(pc_out), 32'(k / 2));
      end
    end
    ack_auto = 1'b0;
    model_pc = 3;

    do_exec(0, 2'b00, 1'b0, 1'b0, 8'h00);
    do_fetch(4, 3);
    do_exec(4, 2'b00, 1'b0, 1'b0, 8'h00);
    do_fetch(5, 0);

    for (int i = 0; i < 9; i++) begin
      do_exec(0, 2'b10, 1'b0, 1'b0, vecs[i].pc);
      mem[vecs[i].pc] = vecs[i].ins;
      do_fetch(int'(vecs[i].pc), 0);
      do_exec(0, vecs[i].bs, vecs[i].ps, vecs[i].z, vecs[i].jmp);
      check($sformatf("vec%0d", i), 32'(imem_addr), 32'(vecs[i].exp));
      do_fetch(model_pc, 0);
    end

    for (int i = 0; i < 150; i++) begin
      do_exec($urandom_range(0, 2), 2'($urandom), 1'($urandom), 1'($urandom), 8'($urandom));
      do_fetch(model_pc, $urandom_range(0, 3));
    end

    // Reset while a fetch is pending and acked in the same cycle.
    do_exec(0, 2'b00, 1'b0, 1'b0, 8'h00);
    ack_man = 1'b1;
    rst_n   = 1'b0;
    tick();
    check("rfetch_req", 32'(imem_req), 32'd0);
    check("rfetch_addr", 32'(imem_addr), 32'd0);
    check("rfetch_valid", 32'(ir_valid), 32'd0);
    check("rfetch_instr", 32'(instruction_out), 32'd0);
    check("rfetch_pc_out", 32'(pc_out), 32'd0);
    rst_n = 1'b1;
    tick();
    check("ridle_req", 32'(imem_req), 32'd1);
    check("ridle_valid", 32'(ir_valid), 32'd0);
    check("ridle_addr", 32'(imem_addr), 32'd0);
    model_pc = 0;
    do_fetch(0, 1);
    do_exec(1, 2'b00, 1'b0, 1'b0, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
